// File: rtl/dense_pkg.sv
// -----------------------------------------------------------------------------
// dense_pkg
//   Shared definitions for the sequential dense (fully connected) layer:
//     - dense_state_e : controller state encoding
//     - acc_width()   : accumulator width for a given word width / input count
//     - sat_max() / sat_min() : signed saturation limits of a WIDTH-bit word
// -----------------------------------------------------------------------------
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for an input vector
    ACC  = 2'd1,  // one multiply-accumulate step per input element
    FIN  = 2'd2,  // requantise accumulators into the output register
    HOLD = 2'd3   // present the result until the consumer takes it
  } dense_state_e;

  // A WIDTH x WIDTH product needs 2*WIDTH bits. Summing n_in of them grows the
  // sum by clog2(n_in) bits. One more bit covers the bias term and the rounding
  // constant, so the accumulator can never wrap.
  function automatic int acc_width(input int width, input int n_in);
    return 2 * width + $clog2(n_in) + 1;
  endfunction

  function automatic int sat_max(input int width);
    return (1 <<< (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 <<< (width - 1));
  endfunction

endpackage : dense_pkg

// File: rtl/dense_requant.sv
// -----------------------------------------------------------------------------
// dense_requant
//   Converts one wide accumulator (2*NFRAC fractional bits) back to a WIDTH-bit
//   word with NFRAC fractional bits: round half up, arithmetic shift, optional
//   ReLU, then saturation. Purely combinational.
//
// Ports
//   acc_i : signed accumulator, ACC_W bits
//   res_o : signed requantised result, WIDTH bits
// -----------------------------------------------------------------------------
module dense_requant
  import dense_pkg::*;
#(
  parameter int ACC_W   = 18,
  parameter int WIDTH   = 6,
  parameter int NFRAC   = 3,
  parameter int RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [WIDTH-1:0] res_o
);

  // Half of one output LSB, expressed in accumulator units.
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 <<< (NFRAC - 1));
  localparam logic signed [ACC_W-1:0] HI   = ACC_W'(sat_max(WIDTH));
  localparam logic signed [ACC_W-1:0] LO   = ACC_W'(sat_min(WIDTH));

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] rectified;
  logic signed [ACC_W-1:0] clamped;

  always_comb begin
    // NOTE: every variable gets a value on entry so no path can leave one
    // unassigned; a missed branch would otherwise infer a latch.
    rounded   = '0;
    shifted   = '0;
    rectified = '0;
    clamped   = '0;

    rounded = acc_i + HALF;
    // Arithmetic shift floors toward minus infinity, so adding HALF first
    // gives round-half-up for both signs.
    shifted = rounded >>> NFRAC;

    if ((RELU_EN != 0) && (shifted < 0)) begin
      rectified = '0;
    end else begin
      rectified = shifted;
    end

    if (rectified > HI) begin
      clamped = HI;
    end else if (rectified < LO) begin
      clamped = LO;
    end else begin
      clamped = rectified;
    end

    res_o = WIDTH'(clamped);
  end

endmodule : dense_requant

// File: rtl/dense_layer_seq.sv
// -----------------------------------------------------------------------------
// dense_layer_seq
//   Sequential dense layer: out[o] = requant(BIAS[o] + sum_i x[i] * W[o][i]).
//   One input element is consumed per cycle; all N_OUT neurons accumulate in
//   parallel. A single vector is in flight at a time.
//
//   Timing: accept edge -> N_IN ACC edges -> FIN edge (out_data registered)
//   -> out_valid rises on the next edge, i.e. N_IN+2 edges after accept.
//
// Ports
//   clk       : clock, all registers update on the rising edge
//   reset     : synchronous, active-high
//   in_valid  : in_data valid
//   in_ready  : high exactly while idle
//   in_data   : N_IN signed WIDTH-bit input vector
//   out_valid : out_data valid, held until out_ready
//   out_ready : consumer accepts out_data
//   out_data  : N_OUT signed WIDTH-bit result vector
// -----------------------------------------------------------------------------
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int N_IN    = 32,
  parameter int N_OUT   = 32,
  parameter int WIDTH   = 6,
  parameter int NFRAC   = 3,
  parameter int RELU_EN = 1,
  parameter logic signed [WIDTH-1:0] WEIGHTS [N_OUT][N_IN] = '{default: '0},
  parameter logic signed [WIDTH-1:0] BIAS    [N_OUT]       = '{default: '0}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data  [N_IN],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data [N_OUT]
);

  localparam int ACC_W  = acc_width(WIDTH, N_IN);
  localparam int PROD_W = 2 * WIDTH;
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

  dense_state_e            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];
  logic signed [WIDTH-1:0] x_q   [N_IN];
  logic signed [WIDTH-1:0] out_data_q [N_OUT];
  logic signed [WIDTH-1:0] out_data_d [N_OUT];
  logic                    out_valid_q, out_valid_d;

  logic signed [PROD_W-1:0] prod [N_OUT];
  logic signed [WIDTH-1:0]  req  [N_OUT];
  logic                     accept;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // ---------------------------------------------------------------------------
  // Datapath: one product per neuron for the current input element.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      prod[o] = PROD_W'(x_q[idx_q]) * PROD_W'(WEIGHTS[o][idx_q]);
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    dense_requant #(
      .ACC_W  (ACC_W),
      .WIDTH  (WIDTH),
      .NFRAC  (NFRAC),
      .RELU_EN(RELU_EN)
    ) u_requant (
      .acc_i(acc_q[g]),
      .res_o(req[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and datapath register enables.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACC;
          idx_d   = '0;
          // Bias is aligned to the 2*NFRAC fractional bits of the products.
          for (int o = 0; o < N_OUT; o++) begin
            acc_d[o] = ACC_W'(BIAS[o]) <<< NFRAC;
          end
        end
      end

      ACC: begin
        for (int o = 0; o < N_OUT; o++) begin
          acc_d[o] = acc_q[o] + ACC_W'(prod[o]);
        end
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      FIN: begin
        out_data_d = req;
        state_d    = HOLD;
      end

      HOLD: begin
        // First HOLD cycle raises out_valid; later cycles wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        acc_q[o]      <= '0;
        out_data_q[o] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: the input vector register has no reset; it is always loaded on the
  // accept edge before any ACC cycle reads it, so its reset value is never seen.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q <= in_data;
    end
  end

endmodule : dense_layer_seq

// File: tb/tb_dense_layer_seq.sv
module tb_dense_layer_seq;

  localparam int N_IN    = 32;
  localparam int N_OUT   = 8;
  localparam int WIDTH   = 6;
  localparam int NFRAC   = 3;
  localparam int LAT     = N_IN + 2;
  localparam int LAT_MAX = N_IN + 8;

  // Lane 0: bias only. Lanes 1/2: +4 / -4 on x[0] (rounding). Lanes 3/4: all
  // +31 / all -32 (saturation, ReLU). Lanes 5..7: mixed weights and biases.
  localparam logic signed [WIDTH-1:0] W_T [N_OUT][N_IN] = '{
    '{default: 6'sd0},
    '{0: 6'sd4, default: 6'sd0},
    '{0: -6'sd4, default: 6'sd0},
    '{default: 6'sd31},
    '{default: -6'sd32},
    '{6'sd3, -6'sd7, 6'sd12, -6'sd1, 6'sd0, 6'sd25, -6'sd18, 6'sd6,
      6'sd9, -6'sd30, 6'sd14, 6'sd2, -6'sd5, 6'sd31, -6'sd11, 6'sd8,
      -6'sd2, 6'sd17, -6'sd26, 6'sd4, 6'sd1, -6'sd9, 6'sd22, -6'sd14,
      6'sd7, -6'sd3, 6'sd19, -6'sd6, 6'sd10, -6'sd21, 6'sd5, -6'sd32},
    '{-6'sd4, 6'sd11, -6'sd15, 6'sd28, -6'sd8, 6'sd0, 6'sd13, -6'sd19,
      6'sd2, 6'sd6, -6'sd27, 6'sd30, -6'sd1, 6'sd9, -6'sd12, 6'sd16,
      6'sd20, -6'sd5, 6'sd3, -6'sd24, 6'sd18, -6'sd10, 6'sd7, -6'sd2,
      -6'sd29, 6'sd14, 6'sd1, -6'sd16, 6'sd23, -6'sd7, 6'sd12, -6'sd3},
    '{6'sd1, 6'sd1, -6'sd1, 6'sd2, -6'sd2, 6'sd3, -6'sd3, 6'sd4,
      -6'sd4, 6'sd5, -6'sd5, 6'sd6, -6'sd6, 6'sd7, -6'sd7, 6'sd8,
      -6'sd8, 6'sd9, -6'sd9, 6'sd10, -6'sd10, 6'sd11, -6'sd11, 6'sd12,
      -6'sd12, 6'sd13, -6'sd13, 6'sd14, -6'sd14, 6'sd15, -6'sd15, 6'sd16}
  };
  localparam logic signed [WIDTH-1:0] B_T [N_OUT] =
    '{6'sd4, 6'sd0, 6'sd0, 6'sd0, 6'sd0, -6'sd3, 6'sd7, -6'sd12};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [WIDTH-1:0] din [N_IN];
  logic rdy_a, rdy_b, ov_a, ov_b;
  logic signed [WIDTH-1:0] dout_a [N_OUT];
  logic signed [WIDTH-1:0] dout_b [N_OUT];

  int total = 0;
  int bad   = 0;

  // Observations recorded by run_txn for the tests to judge.
  int cur_x [N_IN];
  int lat_a, lat_b, hold_bad, acc_rdy_bad;
  logic post_ov, post_rdy;
  logic signed [WIDTH-1:0] snap_a [N_OUT];
  logic signed [WIDTH-1:0] snap_b [N_OUT];
  logic signed [WIDTH-1:0] post_a [N_OUT];

  always #5 clk = ~clk;

  // Two instances share stimulus: u_lin without ReLU, u_relu with ReLU.
  dense_layer_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC), .RELU_EN(0),
    .WEIGHTS(W_T), .BIAS(B_T)
  ) u_lin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .in_data(din),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(dout_a)
  );

  dense_layer_seq #(
    .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC), .RELU_EN(1),
    .WEIGHTS(W_T), .BIAS(B_T)
  ) u_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in_data(din),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(dout_b)
  );

  // Reference: exact real-valued neuron output in output LSBs, rounded half up,
  // optional ReLU, clamped to the signed WIDTH-bit range.
  function automatic int ref_lane(input int lane, input bit relu, input int xs [N_IN]);
    int  sum;
    real v;
    int  r;
    sum = int'(B_T[lane]) * (1 << NFRAC);
    for (int i = 0; i < N_IN; i++) sum += xs[i] * int'(W_T[lane][i]);
    v = real'(sum) / real'(1 << NFRAC);
    r = int'($floor(v + 0.5));
    if (relu && r < 0) r = 0;
    if (r > 31) r = 31;
    if (r < -32) r = -32;
    return r;
  endfunction

  // Drive one vector, scribble on the inputs while busy, hold out_ready low for
  // 'hold' cycles after out_valid, then complete the handshake.
  task automatic run_txn(input int xs [N_IN], input int hold);
    lat_a = -1; lat_b = -1; hold_bad = 0; acc_rdy_bad = 0;
    cur_x = xs;
    for (int i = 0; i < N_IN; i++) din[i] = WIDTH'(xs[i]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= LAT_MAX && (lat_a < 0 || lat_b < 0); k++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < N_IN; i++) din[i] = WIDTH'($urandom);
      @(posedge clk); #1;
      if (ov_a === 1'b1 && lat_a < 0) lat_a = k;
      if (ov_b === 1'b1 && lat_b < 0) lat_b = k;
      if (rdy_a !== 1'b0 || rdy_b !== 1'b0) acc_rdy_bad++;
    end
    snap_a = dout_a;
    snap_b = dout_b;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N_IN; i++) din[i] = WIDTH'($urandom);
      @(posedge clk); #1;
      if (ov_a !== 1'b1 || ov_b !== 1'b1 || rdy_a !== 1'b0 || rdy_b !== 1'b0) hold_bad++;
      for (int o = 0; o < N_OUT; o++)
        if (dout_a[o] !== snap_a[o] || dout_b[o] !== snap_b[o]) hold_bad++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    post_ov  = ov_a | ov_b;
    post_rdy = rdy_a & rdy_b;
    post_a   = dout_a;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b%b want 11", rdy_a, rdy_b);
    end
    total++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b%b want 00", ov_a, ov_b);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (dout_a[o] !== 6'sd0 || dout_b[o] !== 6'sd0) begin
        bad++; $display("FAIL reset_out_data lane%0d: got %0d/%0d want 0", o, dout_a[o], dout_b[o]);
      end
    end
  endtask

  task automatic test_zero_bias();
    int xs [N_IN];
    for (int i = 0; i < N_IN; i++) xs[i] = 0;
    run_txn(xs, 0);
    total++;
    if (lat_a != LAT || lat_b != LAT) begin
      bad++; $display("FAIL zero_latency: got %0d/%0d want %0d", lat_a, lat_b, LAT);
    end
    total++;
    if (snap_a[0] !== 6'sb000100 || snap_b[0] !== 6'sb000100) begin
      bad++; $display("FAIL zero_bias_lane0: got %0d/%0d want 4", snap_a[0], snap_b[0]);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
        bad++; $display("FAIL zero_model lane%0d: got %0d/%0d want %0d/%0d", o, snap_a[o], snap_b[o],
                        ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
      end
    end
    total++;
    if (post_ov !== 1'b0 || post_rdy !== 1'b1) begin
      bad++; $display("FAIL zero_handshake: got valid=%b ready=%b want 0/1", post_ov, post_rdy);
    end
  endtask

  task automatic test_rounding();
    int xs [N_IN];
    for (int i = 0; i < N_IN; i++) xs[i] = 0;
    xs[0] = 1;
    run_txn(xs, 0);
    total++;
    if (snap_a[1] !== 6'sb000001) begin
      bad++; $display("FAIL round_pos: got %0d want 1", snap_a[1]);
    end
    total++;
    if (snap_a[2] !== 6'sb000000) begin
      bad++; $display("FAIL round_neg: got %0d want 0", snap_a[2]);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
        bad++; $display("FAIL round_model lane%0d: got %0d/%0d want %0d/%0d", o, snap_a[o], snap_b[o],
                        ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
      end
    end
  endtask

  task automatic test_saturation();
    int xs [N_IN];
    for (int i = 0; i < N_IN; i++) xs[i] = 31;
    run_txn(xs, 0);
    total++;
    if (snap_a[3] !== 6'sb011111) begin
      bad++; $display("FAIL sat_pos: got %0d want 31", snap_a[3]);
    end
    total++;
    if (snap_a[4] !== 6'sb100000) begin
      bad++; $display("FAIL sat_neg: got %0d want -32", snap_a[4]);
    end
    total++;
    if (snap_b[4] !== 6'sb000000) begin
      bad++; $display("FAIL relu_neg: got %0d want 0", snap_b[4]);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
        bad++; $display("FAIL sat_model lane%0d: got %0d/%0d want %0d/%0d", o, snap_a[o], snap_b[o],
                        ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
      end
    end
  endtask

  task automatic test_random();
    int xs [N_IN];
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 63)) - 32;
      run_txn(xs, int'($urandom_range(0, 3)));
      total++;
      if (lat_a != LAT || lat_b != LAT || acc_rdy_bad != 0 || hold_bad != 0) begin
        bad++; $display("FAIL rand%0d_timing: lat=%0d/%0d busy_ready=%0d unstable=%0d want %0d/%0d 0 0",
                        t, lat_a, lat_b, acc_rdy_bad, hold_bad, LAT, LAT);
      end
      for (int o = 0; o < N_OUT; o++) begin
        total++;
        if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
          bad++; $display("FAIL rand%0d_model lane%0d: got %0d/%0d want %0d/%0d", t, o, snap_a[o], snap_b[o],
                          ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int xs [N_IN];
    for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 63)) - 32;
    run_txn(xs, 10);
    total++;
    if (hold_bad != 0) begin
      bad++; $display("FAIL bp_stable: got %0d unstable samples want 0", hold_bad);
    end
    total++;
    if (post_ov !== 1'b0 || post_rdy !== 1'b1) begin
      bad++; $display("FAIL bp_handshake: got valid=%b ready=%b want 0/1", post_ov, post_rdy);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (int'(post_a[o]) !== ref_lane(o, 1'b0, cur_x)) begin
        bad++; $display("FAIL bp_retain lane%0d: got %0d want %0d", o, post_a[o], ref_lane(o, 1'b0, cur_x));
      end
    end
  endtask

  task automatic test_back_to_back();
    int xs [N_IN];
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 63)) - 32;
      run_txn(xs, 0);
      total++;
      if (lat_a != LAT || post_rdy !== 1'b1) begin
        bad++; $display("FAIL b2b%0d_timing: lat=%0d ready=%b want %0d/1", t, lat_a, post_rdy, LAT);
      end
      for (int o = 0; o < N_OUT; o++) begin
        total++;
        if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
          bad++; $display("FAIL b2b%0d_model lane%0d: got %0d/%0d want %0d/%0d", t, o, snap_a[o], snap_b[o],
                          ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
        end
      end
    end
  endtask

  task automatic test_reset_mid_acc();
    int xs [N_IN];
    for (int i = 0; i < N_IN; i++) din[i] = WIDTH'($urandom);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    total++;
    if (ov_a !== 1'b0 || ov_b !== 1'b0 || rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      bad++; $display("FAIL midacc_ctrl: got valid=%b%b ready=%b%b want 00/11", ov_a, ov_b, rdy_a, rdy_b);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (dout_a[o] !== 6'sd0 || dout_b[o] !== 6'sd0) begin
        bad++; $display("FAIL midacc_data lane%0d: got %0d/%0d want 0", o, dout_a[o], dout_b[o]);
      end
    end
    for (int i = 0; i < N_IN; i++) xs[i] = int'($urandom_range(0, 63)) - 32;
    run_txn(xs, 1);
    total++;
    if (lat_a != LAT || lat_b != LAT) begin
      bad++; $display("FAIL midacc_latency: got %0d/%0d want %0d", lat_a, lat_b, LAT);
    end
    for (int o = 0; o < N_OUT; o++) begin
      total++;
      if (int'(snap_a[o]) !== ref_lane(o, 1'b0, cur_x) || int'(snap_b[o]) !== ref_lane(o, 1'b1, cur_x)) begin
        bad++; $display("FAIL midacc_model lane%0d: got %0d/%0d want %0d/%0d", o, snap_a[o], snap_b[o],
                        ref_lane(o, 1'b0, cur_x), ref_lane(o, 1'b1, cur_x));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) din[i] = '0;
    test_reset();
    test_zero_bias();
    test_rounding();
    test_saturation();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_acc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_dense_layer_seq
